adc_multilane_serial_interface: RTL

Parametrised successor to the single-lane ADC deserialiser. It captures LANES serial ADC data lines in parallel, all framed by one shared `adc_data_ready` and `adc_clock`, and assembles one WORD_WIDTH-bit word per lane each frame. The completed frame is then drained into the downstream sample buffer one lane word per cycle, tagged with its channel index. Frames that cannot be accepted are dropped and flagged as overruns. The block sits between the ADC pins and the sample FIFO.

---
 rtl/adc_if_pkg.sv | 14 +
 rtl/adc_multilane_serial_interface_if.sv | 31 +++
 rtl/adc_lane_deserializer.sv | 33 +++
 rtl/adc_multilane_serial_interface.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/adc_if_pkg.sv
// Shared constants for the multilane ADC deserialiser: FSM encoding,
// bit counter width and drop-counter saturation value.
package adc_if_pkg;

  localparam int BIT_COUNT_W = 6;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CAPTURE = 2'd1;
  localparam state_t ST_DRAIN   = 2'd2;

endpackage

// File: rtl/adc_multilane_serial_interface_if.sv
// Sample-buffer side of the ADC deserialiser: lane word, channel tag,
// write strobe and the FIFO full flag.
interface adc_multilane_serial_interface_if #(
  parameter int WORD_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int CH_W       = (LANES > 1) ? $clog2(LANES) : 1
);
  // Handshake: buffer_write_enable is a one-cycle strobe that qualifies
  // adc_channel_data/adc_channel_index. The source only raises it in a cycle
  // that follows a clock edge where it sampled buffer_full low, so the sink
  // never refuses a word; buffer_full high simply pauses the source.
  logic                  buffer_write_enable;
  logic [WORD_WIDTH-1:0] adc_channel_data;
  logic [CH_W-1:0]       adc_channel_index;
  logic                  buffer_full;

  modport master (
    output buffer_write_enable,
    output adc_channel_data,
    output adc_channel_index,
    input  buffer_full
  );

  modport slave (
    input  buffer_write_enable,
    input  adc_channel_data,
    input  adc_channel_index,
    output buffer_full
  );

endinterface

// File: rtl/adc_lane_deserializer.sv
// One serial ADC lane: input register plus MSB-first shift register.
// word_next is the value the shift register takes on a shift edge.
module adc_lane_deserializer #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  adc_bit,
  input  logic                  clear,
  input  logic                  shift,
  output logic [WORD_WIDTH-1:0] word_next
);

  logic                  d_r;
  logic [WORD_WIDTH-1:0] sh;

  assign word_next = {sh[WORD_WIDTH-2:0], d_r};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_r <= 1'b0;
      sh  <= '0;
    end else begin
      d_r <= adc_bit;
      if (clear) begin
        sh <= '0;
      end else if (shift) begin
        sh <= word_next;
      end
    end
  end

endmodule

// File: rtl/adc_multilane_serial_interface.sv
// Multilane ADC deserialiser: captures LANES serial words per frame and drains
// them to the sample FIFO one lane per cycle. Define ADC_DROP_COUNT_EN to add
// the 16-bit saturating dropped_frame_count output.
module adc_multilane_serial_interface
  import adc_if_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int CH_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   adc_data_ready,
  input  logic                   adc_clock,
  input  logic [LANES-1:0]       adc_data,
  input  logic                   overrun_clear,
  adc_multilane_serial_interface_if.master buf_if,
  output logic                   frame_done,
  output logic                   overrun,
`ifdef ADC_DROP_COUNT_EN
  output logic [15:0]            dropped_frame_count,
`endif
  output state_t                 dbg_state,
  output logic [BIT_COUNT_W-1:0] dbg_bit_count
);

  localparam logic [BIT_COUNT_W-1:0] BC_FULL  = BIT_COUNT_W'(WORD_WIDTH);
  localparam logic [BIT_COUNT_W-1:0] BC_LAST  = BIT_COUNT_W'(WORD_WIDTH - 1);
  localparam logic [CH_W-1:0]        PTR_LAST = CH_W'(LANES - 1);

  logic                              rdy_r, ck_r, ck_r1;
  logic                              fe, clear_en, shift_en, complete, accept, drop;
  state_t                            state;
  logic [BIT_COUNT_W-1:0]            bit_count;
  logic [CH_W-1:0]                   ptr;
  logic [LANES-1:0][WORD_WIDTH-1:0]  sh_next;
  logic [LANES-1:0][WORD_WIDTH-1:0]  hold;

  // Ready wins over a coincident falling edge; a saturated counter ignores edges.
  assign fe       = ck_r1 & ~ck_r;
  assign clear_en = start & rdy_r;
  assign shift_en = start & ~rdy_r & fe & (bit_count < BC_FULL);
  assign complete = shift_en & (bit_count == BC_LAST);
  assign accept   = complete & (state == ST_CAPTURE) & ~buf_if.buffer_full;
  assign drop     = complete & ~accept;

  assign dbg_state     = state;
  assign dbg_bit_count = bit_count;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    adc_lane_deserializer #(.WORD_WIDTH(WORD_WIDTH)) u_lane (
      .clock     (clock),
      .reset_n   (reset_n),
      .adc_bit   (adc_data[l]),
      .clear     (clear_en),
      .shift     (shift_en),
      .word_next (sh_next[l])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_r <= 1'b0;
      ck_r  <= 1'b0;
      ck_r1 <= 1'b0;
    end else begin
      rdy_r <= adc_data_ready;
      ck_r  <= adc_clock;
      ck_r1 <= ck_r;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                      <= ST_IDLE;
      bit_count                  <= BC_FULL;
      ptr                        <= '0;
      hold                       <= '0;
      frame_done                 <= 1'b0;
      buf_if.buffer_write_enable <= 1'b0;
      buf_if.adc_channel_data    <= '0;
      buf_if.adc_channel_index   <= '0;
    end else begin
      frame_done                 <= complete;
      buf_if.buffer_write_enable <= 1'b0;
      if (!start) begin
        state     <= ST_IDLE;
        bit_count <= BC_FULL;
        ptr       <= '0;
      end else begin
        if (rdy_r) begin
          bit_count <= '0;
        end else if (shift_en) begin
          bit_count <= bit_count + 1'b1;
        end
        case (state)
          ST_IDLE: state <= ST_CAPTURE;
          ST_CAPTURE: begin
            if (accept) begin
              hold  <= sh_next;
              ptr   <= '0;
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            // buffer_full pauses the drain with pointer and data held.
            if (!buf_if.buffer_full) begin
              buf_if.buffer_write_enable <= 1'b1;
              buf_if.adc_channel_data    <= hold[ptr];
              buf_if.adc_channel_index   <= ptr;
              ptr                        <= ptr + 1'b1;
              if (ptr == PTR_LAST) begin
                state <= ST_CAPTURE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clear) begin
      overrun <= 1'b0;
    end
  end

`ifdef ADC_DROP_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dropped_frame_count <= '0;
    end else if (drop) begin
      if (overrun_clear) begin
        dropped_frame_count <= 16'd1;
      end else if (dropped_frame_count != DROP_CNT_MAX) begin
        dropped_frame_count <= dropped_frame_count + 16'd1;
      end
    end else if (overrun_clear) begin
      dropped_frame_count <= '0;
    end
  end
`endif

endmodule
